// File: rtl/lane_pkg.sv
// Shared types and constants for the per-lane traffic configuration generator.
package lane_pkg;

  localparam int MAX_CARS   = 5;
  localparam int CAR_WIDTH  = 48;
  localparam int MIN_SPEED  = 1;
  localparam int MAX_SPEED  = 5;
  localparam int TYPE_COUNT = 3;

  // Values stored when a field exhausts its retry budget.
  localparam logic [2:0] FALLBACK_COUNT = 3'd3;
  localparam logic [2:0] FALLBACK_SPEED = 3'd3;
  localparam logic [1:0] FALLBACK_TYPE  = 2'd0;

  // One table entry. car_type[0] is car 1.
  typedef struct packed {
    logic [2:0]      count;
    logic [2:0]      speed;
    logic            face_left;
    logic [4:0][1:0] car_type;
  } lane_cfg_t;

  localparam lane_cfg_t LANE_CFG_RESET = '{count: 3'd0, speed: 3'd1, face_left: 1'b0, car_type: '0};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW_COUNT,
    ST_DRAW_SPEED,
    ST_DRAW_DIR,
    ST_DRAW_TYPE,
    ST_WRITE,
    ST_FINISH
  } lane_state_e;

  function automatic logic count_ok(input logic [2:0] v);
    return int'(v) <= MAX_CARS;
  endfunction

  function automatic logic speed_ok(input logic [2:0] v);
    return (int'(v) >= MIN_SPEED) && (int'(v) <= MAX_SPEED);
  endfunction

  function automatic logic type_ok(input logic [1:0] v);
    return int'(v) < TYPE_COUNT;
  endfunction

endpackage

// File: rtl/lane_config_lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced by 1 so it never locks up.
module lfsr16 (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic [15:0] Seed,
  output logic [15:0] Q
);

  logic [15:0] w_seed;
  logic [15:0] r_q;

  assign w_seed = (Seed == '0) ? 16'h0001 : Seed;

  // Advance one step every cycle, taps 16'hB400.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_q <= w_seed;
    end else begin
      r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/lane_config.sv
// Per-lane traffic configuration generator: draws a new random table each round
// using rejection sampling on a free-running LFSR, with a registered read port.
module lane_config
  import lane_pkg::*;
#(
  parameter int          LaneCount = 8,
  parameter logic [15:0] Seed      = 16'hACE1,
  parameter int          MaxRetry  = 8,
  localparam int         SelW      = (LaneCount > 1) ? $clog2(LaneCount) : 1
) (
  input  logic            Clk,
  input  logic            ResetN,
  input  logic            Start,
  output logic            Busy,
  output logic            Done,
  output logic            Valid,
  input  logic [SelW-1:0] LaneSel,
  output logic [2:0]      CarCount,
  output logic [2:0]      Speed,
  output logic            FaceLeft,
  output logic [9:0]      CarType
);

  localparam int RetryW = (MaxRetry > 1) ? $clog2(MaxRetry) : 1;

  logic [15:0]       w_lfsr;

  lane_state_e       r_state, w_state_nxt;
  logic [RetryW-1:0] r_retry, w_retry_nxt;
  logic [2:0]        r_car, w_car_nxt;
  logic [SelW-1:0]   r_lane, w_lane_nxt;
  lane_cfg_t         r_entry, w_entry_nxt;
  logic              r_valid, w_valid_nxt;
  logic              w_write;

  lane_cfg_t         r_table [LaneCount];
  lane_cfg_t         r_rd;

  logic [2:0]        w_cnt_draw;
  logic [2:0]        w_spd_draw;
  logic [1:0]        w_typ_draw;
  logic              w_cnt_ok;
  logic              w_spd_ok;
  logic              w_typ_ok;
  logic              w_retry_last;

  lfsr16 u_lfsr (
    .Clk    (Clk),
    .ResetN (ResetN),
    .Seed   (Seed),
    .Q      (w_lfsr)
  );

  assign w_cnt_draw   = w_lfsr[2:0];
  assign w_spd_draw   = w_lfsr[5:3];
  assign w_typ_draw   = w_lfsr[8:7];
  assign w_cnt_ok     = count_ok(w_cnt_draw);
  assign w_spd_ok     = speed_ok(w_spd_draw);
  assign w_typ_ok     = type_ok(w_typ_draw);
  assign w_retry_last = (r_retry == RetryW'(MaxRetry - 1));

  // FSM and working-entry registers.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= ST_IDLE;
      r_retry <= '0;
      r_car   <= '0;
      r_lane  <= '0;
      r_entry <= LANE_CFG_RESET;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_retry <= w_retry_nxt;
      r_car   <= w_car_nxt;
      r_lane  <= w_lane_nxt;
      r_entry <= w_entry_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Next-state logic: one draw per cycle, retry until accepted or budget spent.
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_car_nxt   = r_car;
    w_lane_nxt  = r_lane;
    w_entry_nxt = r_entry;
    w_valid_nxt = r_valid;
    w_write     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_state_nxt = ST_DRAW_COUNT;
          w_retry_nxt = '0;
          w_car_nxt   = '0;
          w_lane_nxt  = '0;
          w_valid_nxt = 1'b0;
        end
      end

      ST_DRAW_COUNT: begin
        if (w_cnt_ok || w_retry_last) begin
          w_entry_nxt.count = w_cnt_ok ? w_cnt_draw : FALLBACK_COUNT;
          w_retry_nxt       = '0;
          w_state_nxt       = ST_DRAW_SPEED;
        end else begin
          w_retry_nxt = r_retry + 1'b1;
        end
      end

      ST_DRAW_SPEED: begin
        if (w_spd_ok || w_retry_last) begin
          w_entry_nxt.speed = w_spd_ok ? w_spd_draw : FALLBACK_SPEED;
          w_retry_nxt       = '0;
          w_state_nxt       = ST_DRAW_DIR;
        end else begin
          w_retry_nxt = r_retry + 1'b1;
        end
      end

      ST_DRAW_DIR: begin
        w_entry_nxt.face_left = w_lfsr[6];
        w_car_nxt             = '0;
        w_retry_nxt           = '0;
        w_state_nxt           = ST_DRAW_TYPE;
      end

      ST_DRAW_TYPE: begin
        // Each car index is its own field, so the retry budget restarts per car.
        if (w_typ_ok || w_retry_last) begin
          w_entry_nxt.car_type[r_car] = w_typ_ok ? w_typ_draw : FALLBACK_TYPE;
          w_retry_nxt                 = '0;
          if (int'(r_car) == MAX_CARS - 1) begin
            w_state_nxt = ST_WRITE;
          end else begin
            w_car_nxt = r_car + 1'b1;
          end
        end else begin
          w_retry_nxt = r_retry + 1'b1;
        end
      end

      ST_WRITE: begin
        w_write    = 1'b1;
        w_lane_nxt = r_lane + 1'b1;
        if (int'(r_lane) == LaneCount - 1) begin
          w_state_nxt = ST_FINISH;
          w_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_DRAW_COUNT;
        end
      end

      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Configuration table; register array so reset clears every entry.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int unsigned i = 0; i < LaneCount; i++) begin
        r_table[i] <= LANE_CFG_RESET;
      end
    end else if (w_write) begin
      r_table[r_lane] <= r_entry;
    end
  end

  // Registered read port; out-of-range addresses return the reset entry.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_rd <= LANE_CFG_RESET;
    end else if (int'(LaneSel) < LaneCount) begin
      r_rd <= r_table[LaneSel];
    end else begin
      r_rd <= LANE_CFG_RESET;
    end
  end

  assign Busy     = (r_state != ST_IDLE) && (r_state != ST_FINISH);
  assign Done     = (r_state == ST_FINISH);
  assign Valid    = r_valid;
  assign CarCount = r_rd.count;
  assign Speed    = r_rd.speed;
  assign FaceLeft = r_rd.face_left;
  assign CarType  = r_rd.car_type;

endmodule

// File: tb/tb_lane_config.sv
// Self-checking bench for lane_config: reset state, round timing, table contents
// against a reference LFSR/draw model, re-pulsed Start, mid-round reset, zero seed
// and fallback values (second instance with a one-draw retry budget).
module tb_lane_config;
  import lane_pkg::*;

  localparam int LIMIT = 600;

  logic       Clk;
  logic       ResetN;
  logic       Start_a, Start_b;
  logic       Busy_a, Busy_b, Done_a, Done_b, Valid_a, Valid_b;
  logic [2:0] LaneSel_a, LaneSel_b;
  logic [2:0] CarCount_a, CarCount_b, Speed_a, Speed_b;
  logic       FaceLeft_a, FaceLeft_b;
  logic [9:0] CarType_a, CarType_b;

  int n_checks = 0;
  int n_errors = 0;

  lane_cfg_t  mdl [8];
  int         mdl_cycles;
  logic [15:0] m_lfsr_a, m_lfsr_b;
  bit seen_c0, seen_c5, seen_s1, seen_s5;

  lane_config #(.LaneCount(8), .Seed(16'hACE1), .MaxRetry(8)) dut_a (
    .Clk(Clk), .ResetN(ResetN), .Start(Start_a), .Busy(Busy_a), .Done(Done_a),
    .Valid(Valid_a), .LaneSel(LaneSel_a), .CarCount(CarCount_a), .Speed(Speed_a),
    .FaceLeft(FaceLeft_a), .CarType(CarType_a)
  );

  lane_config #(.LaneCount(5), .Seed(16'h0000), .MaxRetry(1)) dut_b (
    .Clk(Clk), .ResetN(ResetN), .Start(Start_b), .Busy(Busy_b), .Done(Done_b),
    .Valid(Valid_b), .LaneSel(LaneSel_b), .CarCount(CarCount_b), .Speed(Speed_b),
    .FaceLeft(FaceLeft_b), .CarType(CarType_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSRs, stepping in lock-step with the DUTs (B uses the zero-seed substitute).
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      m_lfsr_a <= 16'hACE1;
      m_lfsr_b <= 16'h0001;
    end else begin
      m_lfsr_a <= lfsr_step(m_lfsr_a);
      m_lfsr_b <= lfsr_step(m_lfsr_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // kind 0 = count, 1 = speed, 2 = type; one LFSR step per draw.
  task automatic mdl_field(input int kind, input int maxr, inout logic [15:0] l,
                           inout int cyc, output logic [2:0] v);
    for (int r = 0; r < maxr; r++) begin
      logic [2:0] d;
      logic ok;
      case (kind)
        0:       begin d = l[2:0];          ok = (d <= 3'd5); end
        1:       begin d = l[5:3];          ok = (d >= 3'd1) && (d <= 3'd5); end
        default: begin d = {1'b0, l[8:7]};  ok = (d != 3'd3); end
      endcase
      cyc++;
      l = lfsr_step(l);
      if (ok) begin
        v = d;
        return;
      end
    end
    v = (kind == 0) ? 3'd3 : (kind == 1) ? 3'd3 : 3'd0;
  endtask

  // Whole round from the LFSR value seen in the first draw cycle.
  task automatic model_round(input logic [15:0] l0, input int lanes, input int maxr);
    logic [15:0] l;
    logic [2:0]  v;
    int cyc;
    l = l0;
    cyc = 0;
    for (int ln = 0; ln < lanes; ln++) begin
      mdl_field(0, maxr, l, cyc, v); mdl[ln].count = v;
      mdl_field(1, maxr, l, cyc, v); mdl[ln].speed = v;
      mdl[ln].face_left = l[6];
      cyc++; l = lfsr_step(l);
      for (int t = 0; t < 5; t++) begin
        mdl_field(2, maxr, l, cyc, v);
        mdl[ln].car_type[t] = v[1:0];
      end
      cyc++; l = lfsr_step(l);
    end
    mdl_cycles = cyc;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic get_busy(input int w);  return w != 0 ? Busy_b  : Busy_a;  endfunction
  function automatic logic get_done(input int w);  return w != 0 ? Done_b  : Done_a;  endfunction
  function automatic logic get_valid(input int w); return w != 0 ? Valid_b : Valid_a; endfunction

  task automatic read_lane(input int which, input int lane, input lane_cfg_t exp, input bit track);
    lane_cfg_t got;
    if (which != 0) LaneSel_b = 3'(lane);
    else            LaneSel_a = 3'(lane);
    step();
    got = (which != 0) ? {CarCount_b, Speed_b, FaceLeft_b, CarType_b}
                       : {CarCount_a, Speed_a, FaceLeft_a, CarType_a};
    check($sformatf("dut%0d_lane%0d", which, lane), got, exp);
    if (track) begin
      check("count_range", 32'(got.count <= 3'd5), 1);
      check("speed_range", 32'((got.speed >= 3'd1) && (got.speed <= 3'd5)), 1);
      for (int t = 0; t < 5; t++) check("type_range", 32'(got.car_type[t] != 2'd3), 1);
      if (got.count == 3'd0) seen_c0 = 1'b1;
      if (got.count == 3'd5) seen_c5 = 1'b1;
      if (got.speed == 3'd1) seen_s1 = 1'b1;
      if (got.speed == 3'd5) seen_s5 = 1'b1;
    end
  endtask

  task automatic do_round(input int which, input bit hold, input bit track);
    logic [15:0] l0;
    int k, ndone, lanes;
    bit seen;
    lanes = (which != 0) ? 5 : 8;
    if (which != 0) Start_b = 1'b1; else Start_a = 1'b1;
    step();
    l0 = (which != 0) ? m_lfsr_b : m_lfsr_a;
    if (!hold) begin
      Start_a = 1'b0;
      Start_b = 1'b0;
    end
    check("busy_rise", 32'(get_busy(which)), 1);
    check("valid_drop", 32'(get_valid(which)), 0);
    model_round(l0, lanes, (which != 0) ? 1 : 8);
    seen = 1'b0;
    ndone = 0;
    k = 0;
    while (!seen && k < LIMIT) begin
      step();
      k++;
      if (get_done(which)) begin
        seen = 1'b1;
        ndone++;
      end
    end
    Start_a = 1'b0;
    Start_b = 1'b0;
    check("done_latency", k, mdl_cycles);
    check("busy_fall", 32'(get_busy(which)), 0);
    check("valid_rise", 32'(get_valid(which)), 1);
    repeat (3) begin
      step();
      if (get_done(which)) ndone++;
    end
    check("single_done", ndone, 1);
    for (int ln = 0; ln < lanes; ln++) read_lane(which, ln, mdl[ln], track);
  endtask

  task automatic check_reset_tables();
    for (int ln = 0; ln < 8; ln++) read_lane(0, ln, LANE_CFG_RESET, 1'b0);
    for (int ln = 0; ln < 8; ln++) read_lane(1, ln, LANE_CFG_RESET, 1'b0);
  endtask

  initial begin
    ResetN    = 1'b0;
    Start_a   = 1'b0;
    Start_b   = 1'b0;
    LaneSel_a = '0;
    LaneSel_b = '0;
    seen_c0 = 1'b0; seen_c5 = 1'b0; seen_s1 = 1'b0; seen_s5 = 1'b0;

    // Reset state.
    step();
    step();
    check("rst_busy",  32'(Busy_a),  0);
    check("rst_done",  32'(Done_a),  0);
    check("rst_valid", 32'(Valid_a), 0);
    check("rst_busy_b",  32'(Busy_b),  0);
    check("rst_valid_b", 32'(Valid_b), 0);
    ResetN = 1'b1;
    check_reset_tables();

    // Single-pulse round, then zero-seed/fallback instance, then re-pulsed Start.
    repeat (4) step();
    do_round(0, 1'b0, 1'b1);
    do_round(1, 1'b0, 1'b1);
    repeat (2) step();
    do_round(0, 1'b1, 1'b1);

    // Rounds with random gaps between Start pulses.
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(0, 17)) step();
      do_round(0, 1'b0, 1'b1);
    end
    check("cov_count0", 32'(seen_c0), 1);
    check("cov_count5", 32'(seen_c5), 1);
    check("cov_speed1", 32'(seen_s1), 1);
    check("cov_speed5", 32'(seen_s5), 1);

    // Reset while generation is in progress (around lane 3).
    Start_a = 1'b1;
    step();
    Start_a = 1'b0;
    repeat (30) step();
    check("mid_busy_before", 32'(Busy_a), 1);
    ResetN = 1'b0;
    #1;
    check("mid_rst_busy",  32'(Busy_a),  0);
    check("mid_rst_valid", 32'(Valid_a), 0);
    check("mid_rst_done",  32'(Done_a),  0);
    step();
    ResetN = 1'b1;
    check_reset_tables();
    do_round(0, 1'b0, 1'b0);

    // Same seed and same Start offset after reset gives the same table, twice.
    for (int rep = 0; rep < 2; rep++) begin
      ResetN = 1'b0;
      step();
      ResetN = 1'b1;
      repeat (7) step();
      do_round(0, 1'b0, 1'b0);
      do_round(1, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
